// File: rtl/jb_hazard_ctrl.sv
// Decode-stage hazard sequencer for branches/jumps resolved in ID from raw regfile reads.
// Stalls IF/ID and bubbles ID/EX until operands are written, qualifies redirects, counts events.
module jb_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_id_valid,
    input  logic [1:0]       i_id_jb_sel,
    input  logic             i_id_uses_rs1,
    input  logic             i_id_uses_rs2,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_jb_taken,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_load_regfile,
    input  logic             i_ex_is_load,
    input  logic [4:0]       i_mem_rd,
    input  logic             i_mem_load_regfile,
    input  logic             i_mem_stall,
    output logic             o_stall_if_id,
    output logic             o_bubble_id_ex,
    output logic             o_stall_all,
    output logic             o_pc_redirect,
    output logic             o_flush_if_id,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_redirect_count,
    output logic             o_fsm_state
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_redirect_count;

    logic       w_ex_hit1, w_ex_hit2, w_mem_hit1, w_mem_hit2;
    logic [1:0] w_depth;
    logic       w_hold;
    logic       w_redirect;

    // WB producers never appear here: the regfile writes through to the same-cycle ID read.
    assign w_ex_hit1  = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd) && (i_ex_rd != 5'd0) && i_ex_load_regfile;
    assign w_ex_hit2  = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd) && (i_ex_rd != 5'd0) && i_ex_load_regfile;
    assign w_mem_hit1 = i_id_uses_rs1 && (i_id_rs1 == i_mem_rd) && (i_mem_rd != 5'd0) && i_mem_load_regfile;
    assign w_mem_hit2 = i_id_uses_rs2 && (i_id_rs2 == i_mem_rd) && (i_mem_rd != 5'd0) && i_mem_load_regfile;

    always_comb begin
        w_depth = 2'd0;
        if ((r_state == ST_RUN) && i_id_valid && !i_mem_stall) begin
            case (i_id_jb_sel)
                2'b00: begin
                    if (w_ex_hit1 || w_ex_hit2)        w_depth = 2'd2;
                    else if (w_mem_hit1 || w_mem_hit2) w_depth = 2'd1;
                end
                2'b10: begin
                    if (w_ex_hit1)       w_depth = 2'd2;
                    else if (w_mem_hit1) w_depth = 2'd1;
                end
                default: begin
                    if ((w_ex_hit1 || w_ex_hit2) && i_ex_is_load) w_depth = 2'd1;
                end
            endcase
        end
    end

    assign w_hold     = rst_n && !i_mem_stall && ((r_state == ST_WAIT) || (w_depth != 2'd0));
    assign w_redirect = rst_n && !i_mem_stall && i_jb_taken && i_id_valid && (i_id_jb_sel != 2'b11)
                        && (r_state == ST_RUN) && (w_depth == 2'd0);

    assign o_stall_if_id    = w_hold;
    assign o_bubble_id_ex   = w_hold;
    assign o_stall_all      = rst_n && i_mem_stall;
    assign o_pc_redirect    = w_redirect;
    assign o_flush_if_id    = w_redirect;
    assign o_stall_cycles   = r_stall_cycles;
    assign o_redirect_count = r_redirect_count;
    assign o_fsm_state      = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_RUN;
            r_wait_cnt       <= 2'd0;
            r_stall_cycles   <= '0;
            r_redirect_count <= '0;
        end else begin
            // A memory stall freezes sequencing; the counters below are gated by w_hold/w_redirect.
            if (!i_mem_stall) begin
                case (r_state)
                    ST_RUN: begin
                        if (w_depth == 2'd2) begin
                            r_wait_cnt <= 2'd1;
                            r_state    <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                        if (r_wait_cnt == 2'd1) r_state <= ST_RUN;
                    end
                    default: r_state <= ST_RUN;
                endcase
            end
            if (w_hold && (r_stall_cycles != {CNT_W{1'b1}}))
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if (w_redirect && (r_redirect_count != {CNT_W{1'b1}}))
                r_redirect_count <= r_redirect_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_jb_hazard_ctrl.sv
// Scoreboard bench for jb_hazard_ctrl: driver pushes per-cycle expectations from a
// remaining-stall-cycles reference model, a monitor pops and compares each cycle.
module tb_jb_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int EW    = 5 + 2 * CNT_W;
    localparam int SAT   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       valid;
        logic [1:0] sel;
        logic       u1;
        logic       u2;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       taken;
        logic [4:0] ex_rd;
        logic       ex_lr;
        logic       ex_ld;
        logic [4:0] mem_rd;
        logic       mem_lr;
        logic       mstall;
    } stim_t;

    logic             clk;
    logic             rst_n;
    logic             id_valid, id_uses_rs1, id_uses_rs2, jb_taken;
    logic [1:0]       id_jb_sel;
    logic [4:0]       id_rs1, id_rs2, ex_rd, mem_rd;
    logic             ex_load_regfile, ex_is_load, mem_load_regfile, mem_stall;
    logic             stall_if_id, bubble_id_ex, stall_all, pc_redirect, flush_if_id;
    logic [CNT_W-1:0] stall_cycles, redirect_count;
    logic             fsm_state;

    jb_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_id_valid         (id_valid),
        .i_id_jb_sel        (id_jb_sel),
        .i_id_uses_rs1      (id_uses_rs1),
        .i_id_uses_rs2      (id_uses_rs2),
        .i_id_rs1           (id_rs1),
        .i_id_rs2           (id_rs2),
        .i_jb_taken         (jb_taken),
        .i_ex_rd            (ex_rd),
        .i_ex_load_regfile  (ex_load_regfile),
        .i_ex_is_load       (ex_is_load),
        .i_mem_rd           (mem_rd),
        .i_mem_load_regfile (mem_load_regfile),
        .i_mem_stall        (mem_stall),
        .o_stall_if_id      (stall_if_id),
        .o_bubble_id_ex     (bubble_id_ex),
        .o_stall_all        (stall_all),
        .o_pc_redirect      (pc_redirect),
        .o_flush_if_id      (flush_if_id),
        .o_stall_cycles     (stall_cycles),
        .o_redirect_count   (redirect_count),
        .o_fsm_state        (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q[$];

    // reference model: stall cycles still owed, and saturating event totals
    int m_pend = 0;
    int m_sc   = 0;
    int m_rc   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int depth(input stim_t s);
        bit e1, e2, m1, m2;
        e1 = s.u1 && (s.rs1 == s.ex_rd)  && (s.ex_rd != 0)  && s.ex_lr;
        e2 = s.u2 && (s.rs2 == s.ex_rd)  && (s.ex_rd != 0)  && s.ex_lr;
        m1 = s.u1 && (s.rs1 == s.mem_rd) && (s.mem_rd != 0) && s.mem_lr;
        m2 = s.u2 && (s.rs2 == s.mem_rd) && (s.mem_rd != 0) && s.mem_lr;
        if (!s.valid) return 0;
        if (s.sel == 2'b00) return (e1 || e2) ? 2 : ((m1 || m2) ? 1 : 0);
        if (s.sel == 2'b10) return e1 ? 2 : (m1 ? 1 : 0);
        return ((e1 || e2) && s.ex_ld) ? 1 : 0;
    endfunction

    // driver: apply one cycle of inputs just after the rising edge and push its expectation
    task automatic step(input stim_t s, input logic rst_v);
        logic e_st, e_bub, e_sa, e_rd;
        int   n;
        @(posedge clk);
        #1;
        rst_n            = rst_v;
        id_valid         = s.valid;
        id_jb_sel        = s.sel;
        id_uses_rs1      = s.u1;
        id_uses_rs2      = s.u2;
        id_rs1           = s.rs1;
        id_rs2           = s.rs2;
        jb_taken         = s.taken;
        ex_rd            = s.ex_rd;
        ex_load_regfile  = s.ex_lr;
        ex_is_load       = s.ex_ld;
        mem_rd           = s.mem_rd;
        mem_load_regfile = s.mem_lr;
        mem_stall        = s.mstall;
        e_st = 1'b0; e_bub = 1'b0; e_sa = 1'b0; e_rd = 1'b0;
        if (!rst_v) begin
            m_pend = 0; m_sc = 0; m_rc = 0;
        end else if (s.mstall) begin
            e_sa = 1'b1;
        end else if (m_pend > 0) begin
            e_st = 1'b1; e_bub = 1'b1;
            m_pend--;
        end else begin
            n = depth(s);
            if (n > 0) begin
                e_st = 1'b1; e_bub = 1'b1;
                m_pend = n - 1;
            end else if (s.taken && s.valid && (s.sel != 2'b11)) begin
                e_rd = 1'b1;
            end
        end
        exp_q.push_back({e_st, e_bub, e_sa, e_rd, e_rd, CNT_W'(m_sc), CNT_W'(m_rc)});
        if (e_bub && m_sc < SAT) m_sc++;
        if (e_rd && m_rc < SAT) m_rc++;
    endtask

    // monitor: compare every presented cycle on the falling edge
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall_if_id",    int'(stall_if_id),    int'(e[EW-1]));
                chk("bubble_id_ex",   int'(bubble_id_ex),   int'(e[EW-2]));
                chk("stall_all",      int'(stall_all),      int'(e[EW-3]));
                chk("pc_redirect",    int'(pc_redirect),    int'(e[EW-4]));
                chk("flush_if_id",    int'(flush_if_id),    int'(e[EW-5]));
                chk("stall_cycles",   int'(stall_cycles),   int'(e[2*CNT_W-1:CNT_W]));
                chk("redirect_count", int'(redirect_count), int'(e[CNT_W-1:0]));
            end
        end
    end

    stim_t s, z;

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_jb_sel = 2'b11; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_rs1 = 0; id_rs2 = 0; jb_taken = 0; ex_rd = 0; ex_load_regfile = 0;
        ex_is_load = 0; mem_rd = 0; mem_load_regfile = 0; mem_stall = 0;
        z = '0; z.sel = 2'b11;

        step(z, 1'b0);
        step(z, 1'b0);

        // beq x5,x6 with addi x5 in EX: two stalls then one redirect
        s = '0; s.valid = 1; s.sel = 2'b00; s.u1 = 1; s.u2 = 1; s.rs1 = 5; s.rs2 = 6;
        s.taken = 1; s.ex_rd = 5; s.ex_lr = 1;
        step(s, 1'b1);
        step(s, 1'b1);
        s.ex_rd = 0; s.ex_lr = 0;
        step(s, 1'b1);
        step(z, 1'b1);
        @(negedge clk); #2;
        chk("beq_ex_stall_total", int'(stall_cycles), 2);
        chk("beq_ex_redirects",   int'(redirect_count), 1);

        // jalr x1,0(x7) with x7 in MEM: one stall, then redirect; mem_rd=0 gives none
        step(z, 1'b0);
        s = '0; s.valid = 1; s.sel = 2'b10; s.u1 = 1; s.rs1 = 7; s.taken = 1;
        s.mem_rd = 7; s.mem_lr = 1;
        step(s, 1'b1);
        s.mem_rd = 0; s.mem_lr = 0;
        step(s, 1'b1);
        s.mem_rd = 0; s.mem_lr = 1;
        step(s, 1'b1);
        step(z, 1'b1);

        // load-use on rs2 of a non-control op; non-load producer does not stall
        s = '0; s.valid = 1; s.sel = 2'b11; s.u2 = 1; s.rs2 = 3; s.ex_rd = 3; s.ex_lr = 1; s.ex_ld = 1;
        step(s, 1'b1);
        s.ex_rd = 0;
        step(s, 1'b1);
        s.ex_rd = 3; s.ex_ld = 0;
        step(s, 1'b1);
        step(z, 1'b1);

        // memory stall during WAIT holds the sequence
        step(z, 1'b0);
        s = '0; s.valid = 1; s.sel = 2'b00; s.u1 = 1; s.rs1 = 5; s.taken = 1; s.ex_rd = 5; s.ex_lr = 1;
        step(s, 1'b1);
        s.mstall = 1;
        repeat (3) step(s, 1'b1);
        s.mstall = 0;
        step(s, 1'b1);
        s.ex_rd = 0; s.ex_lr = 0;
        step(s, 1'b1);
        step(z, 1'b1);
        @(negedge clk); #2;
        chk("memstall_stall_total", int'(stall_cycles), 2);
        chk("memstall_redirects",   int'(redirect_count), 1);

        // reset pulsed in WAIT with the hazard still presented
        s = '0; s.valid = 1; s.sel = 2'b00; s.u1 = 1; s.rs1 = 5; s.taken = 1; s.ex_rd = 5; s.ex_lr = 1;
        step(s, 1'b1);
        step(s, 1'b0);
        step(z, 1'b1);
        step(z, 1'b1);

        // randomized traffic with small register numbers to provoke matches
        for (int i = 0; i < 500; i++) begin
            s.valid  = ($urandom_range(0, 9) != 0);
            s.sel    = 2'($urandom_range(0, 3));
            s.u1     = 1'($urandom_range(0, 1));
            s.u2     = 1'($urandom_range(0, 1));
            s.rs1    = 5'($urandom_range(0, 3));
            s.rs2    = 5'($urandom_range(0, 3));
            s.taken  = 1'($urandom_range(0, 1));
            s.ex_rd  = 5'($urandom_range(0, 3));
            s.ex_lr  = 1'($urandom_range(0, 1));
            s.ex_ld  = 1'($urandom_range(0, 1));
            s.mem_rd = 5'($urandom_range(0, 3));
            s.mem_lr = 1'($urandom_range(0, 1));
            s.mstall = ($urandom_range(0, 6) == 0);
            step(s, ($urandom_range(0, 60) != 0));
        end

        // saturation of the stall counter at 15
        step(z, 1'b0);
        s = '0; s.valid = 1; s.sel = 2'b11; s.u1 = 1; s.rs1 = 9; s.ex_rd = 9; s.ex_lr = 1; s.ex_ld = 1;
        repeat (20) step(s, 1'b1);
        step(z, 1'b1);
        @(negedge clk); #2;
        chk("stall_cnt_saturated", int'(stall_cycles), SAT);

        @(negedge clk); #2;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
